adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 87 ++++++++
 tb/tb_adder_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: 3-way round-robin arbiter sharing one 5-bit adder, result held in a handshake register
module adder5 (
  input  logic a4, a3, a2, a1, a0,
  input  logic b4, b3, b2, b1, b0,
  output logic q4, q3, q2, q1, q0,
  output logic overflow
);
  logic c1, c2, c3, c4;
  assign q0 = a0 ^ b0;
  assign c1 = a0 & b0;
  assign q1 = a1 ^ b1 ^ c1;
  assign c2 = (a1 & b1) | (c1 & (a1 ^ b1));
  assign q2 = a2 ^ b2 ^ c2;
  assign c3 = (a2 & b2) | (c2 & (a2 ^ b2));
  assign q3 = a3 ^ b3 ^ c3;
  assign c4 = (a3 & b3) | (c3 & (a3 ^ b3));
  assign q4 = a4 ^ b4 ^ c4;
  assign overflow = (a4 & b4) | (c4 & (a4 ^ b4));
endmodule

module adder_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_valid,
  input  logic [14:0] req_a,
  input  logic [14:0] req_b,
  output logic [2:0]  req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [4:0]  rsp_sum,
  output logic        rsp_overflow,
  output logic [1:0]  rsp_id,
  output logic [7:0]  ovf_count
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state_q, state_d;
  logic [1:0] last_q, last_d, id_q, id_d, first, second, win;
  logic [4:0] sum_q, sum_d, a_sel, b_sel, q;
  logic [7:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, ovf, accept, xfer;
  adder5 u_add (
    .a4(a_sel[4]), .a3(a_sel[3]), .a2(a_sel[2]), .a1(a_sel[1]), .a0(a_sel[0]),
    .b4(b_sel[4]), .b3(b_sel[3]), .b2(b_sel[2]), .b1(b_sel[1]), .b0(b_sel[0]),
    .q4(q[4]), .q3(q[3]), .q2(q[2]), .q1(q[1]), .q0(q[0]),
    .overflow(ovf)
  );
  // Round-robin pick starting after last grant, grant only while the result slot can take a value and reset is low
  always_comb begin
    accept    = (state_q == EMPTY) || rsp_ready;
    first     = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    second    = (first == 2'd2) ? 2'd0 : first + 2'd1;
    win       = req_valid[first] ? first : req_valid[second] ? second : last_q;
    xfer      = accept && !rst && (|req_valid);
    req_ready = xfer ? (3'b001 << win) : 3'b000;
    a_sel     = (win == 2'd0) ? req_a[4:0] : (win == 2'd1) ? req_a[9:5] : req_a[14:10];
    b_sel     = (win == 2'd0) ? req_b[4:0] : (win == 2'd1) ? req_b[9:5] : req_b[14:10];
    state_d   = xfer ? FULL : (state_q == FULL && rsp_ready) ? EMPTY : state_q;
    last_d    = xfer ? win : last_q;
    sum_d     = xfer ? q : sum_q;
    ovf_d     = xfer ? ovf : ovf_q;
    id_d      = xfer ? win : id_q;
    cnt_d     = (xfer && ovf && cnt_q != 8'hff) ? cnt_q + 8'd1 : cnt_q;
  end
  // Controller state and result register; last_grant resets to 2 so requester 0 goes first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      last_q  <= 2'd2;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      id_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end
  assign rsp_valid    = (state_q == FULL);
  assign rsp_sum      = sum_q;
  assign rsp_overflow = ovf_q;
  assign rsp_id       = id_q;
  assign ovf_count    = cnt_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed checks of arbitration, handshake, reset and arithmetic
module tb_adder_arbiter;
  logic clk = 0, rst = 1, rsp_ready = 0, rsp_valid, rsp_overflow;
  logic [2:0] req_valid = 0, req_ready;
  logic [14:0] req_a = 0, req_b = 0;
  logic [4:0] rsp_sum;
  logic [1:0] rsp_id;
  logic [7:0] ovf_count;
  int n_chk = 0, n_fail = 0;
  adder_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_overflow(rsp_overflow), .rsp_id(rsp_id), .ovf_count(ovf_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int seq [4] = '{0, 1, 2, 0};
    int sums [3] = '{3, 9, 13};
    int cnt;
    req_valid = 3'b111;
    tick();
    tick();
    check("rst_ready", req_ready, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_sum", rsp_sum, 0);
    check("rst_id", rsp_id, 0);
    check("rst_cnt", ovf_count, 0);
    req_valid = 0;
    rst = 0;
    // single request
    req_valid = 3'b001; req_a[4:0] = 3; req_b[4:0] = 5; rsp_ready = 1;
    #1 check("single_ready", req_ready, 3'b001);
    tick();
    req_valid = 0;
    check("single_valid", rsp_valid, 1);
    check("single_sum", rsp_sum, 8);
    check("single_ovf", rsp_overflow, 0);
    check("single_id", rsp_id, 0);
    // overflow on requester 2
    req_valid = 3'b100; req_a[14:10] = 31; req_b[14:10] = 31;
    #1 check("ovf_ready", req_ready, 3'b100);
    tick();
    req_valid = 0;
    check("ovf_sum", rsp_sum, 30);
    check("ovf_flag", rsp_overflow, 1);
    check("ovf_id", rsp_id, 2);
    check("ovf_cnt", ovf_count, 1);
    tick();
    check("drain_valid", rsp_valid, 0);
    // round robin with all requesters
    req_a = {5'd6, 5'd4, 5'd1}; req_b = {5'd7, 5'd5, 5'd2};
    req_valid = 3'b111;
    for (int i = 0; i < 4; i++) begin
      #1 check("rr_ready", req_ready, 3'b001 << seq[i]);
      tick();
      check("rr_id", rsp_id, seq[i]);
      check("rr_sum", rsp_sum, sums[seq[i]]);
      check("rr_valid", rsp_valid, 1);
    end
    // backpressure
    rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_ready", req_ready, 0);
      tick();
      check("bp_valid", rsp_valid, 1);
      check("bp_id", rsp_id, 0);
      check("bp_sum", rsp_sum, 3);
    end
    rsp_ready = 1;
    #1 check("bp_release_ready", req_ready, 3'b010);
    tick();
    check("bp_release_id", rsp_id, 1);
    check("bp_release_sum", rsp_sum, 9);
    // mid-stall reset
    rsp_ready = 0;
    tick();
    check("stall_valid", rsp_valid, 1);
    rst = 1;
    #1 check("mrst_valid", rsp_valid, 0);
    check("mrst_cnt", ovf_count, 0);
    check("mrst_ready", req_ready, 0);
    #1 rst = 0;
    rsp_ready = 1;
    #1 check("mrst_grant", req_ready, 3'b001);
    tick();
    check("mrst_id", rsp_id, 0);
    // saturation: 260 overflows via requester 1
    req_valid = 3'b010; req_a[9:5] = 31; req_b[9:5] = 30;
    cnt = 0;
    for (int i = 0; i < 260; i++) begin
      tick();
      cnt = (cnt == 255) ? 255 : cnt + 1;
      if (i == 0 || i >= 253) check("sat_cnt", ovf_count, cnt);
    end
    check("sat_final", ovf_count, 255);
    // exhaustive operand sweep via requester 1
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        req_a[9:5] = a[4:0]; req_b[9:5] = b[4:0];
        tick();
        check("ex_sum", rsp_sum, (a + b) % 32);
        check("ex_ovf", rsp_overflow, (a + b > 31) ? 1 : 0);
        check("ex_id", rsp_id, 1);
      end
    end
    check("ex_cnt", ovf_count, 255);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
